// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the soc_system PIO blocks: register map, STATUS bit
// positions and the command-output handshake state.
package soc_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_SET    = 2'd2;
  localparam logic [1:0] ADDR_CLEAR  = 2'd3;

  localparam int unsigned STAT_PENDING  = 0;
  localparam int unsigned STAT_OVERFLOW = 1;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StPend = 1'b1
  } cmd_state_e;

endpackage

// File: rtl/soc_system_cmd_out_if.sv
// Avalon-MM slave bus plus the valid/ready command stream toward the fabric.
interface soc_system_cmd_out_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic [1:0]            address;
  logic                  chipselect;
  logic                  write_n;
  logic [31:0]           writedata;
  logic [31:0]           readdata;
  logic [DATA_WIDTH-1:0] out_port;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output out_port,
    output out_valid,
    input  out_ready
  );

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata,
    input  out_port,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/soc_system_cmd_out.sv
// HPS-to-fabric command register: Avalon-MM writes load a command word that is
// offered to the fabric with valid/ready; writes while pending are dropped.
module soc_system_cmd_out
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input logic                  clk,
  input logic                  reset_n,
  soc_system_cmd_out_if.slave  bus
);

  cmd_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  overflow_q, overflow_d;
  logic [31:0]           readdata_q, readdata_d;

  logic                  wr_cycle;
  logic                  cmd_wr;
  logic [DATA_WIDTH-1:0] wr_bits;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  unused_writedata;

  assign wr_cycle = bus.chipselect && !bus.write_n;
  assign cmd_wr   = wr_cycle && (bus.address != ADDR_STATUS);
  assign wr_bits  = bus.writedata[DATA_WIDTH-1:0];
  // Bits above DATA_WIDTH are ignored by design.
  assign unused_writedata = ^bus.writedata;

  always_comb begin
    cmd_data = wr_bits;
    unique case (bus.address)
      ADDR_SET:   cmd_data = data_q | wr_bits;
      ADDR_CLEAR: cmd_data = data_q & ~wr_bits;
      default:    cmd_data = wr_bits;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    overflow_d = overflow_q;

    if (wr_cycle && (bus.address == ADDR_STATUS) && bus.writedata[STAT_OVERFLOW]) begin
      overflow_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_wr) begin
          data_d  = cmd_data;
          state_d = StPend;
        end
      end
      StPend: begin
        if (bus.out_ready) begin
          // A command write in the completing cycle re-arms immediately.
          if (cmd_wr) begin
            data_d = cmd_data;
          end else begin
            state_d = StIdle;
          end
        end else if (cmd_wr) begin
          overflow_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    readdata_d = '0;
    unique case (bus.address)
      ADDR_DATA: readdata_d[DATA_WIDTH-1:0] = data_q;
      ADDR_STATUS: begin
        readdata_d[STAT_PENDING]  = (state_q == StPend);
        readdata_d[STAT_OVERFLOW] = overflow_q;
      end
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      data_q     <= RESET_VALUE;
      overflow_q <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.out_port  = data_q;
  assign bus.out_valid = (state_q == StPend);
  assign bus.readdata  = readdata_q;

endmodule

// File: tb/tb_soc_system_cmd_out.sv
// Directed bench for soc_system_cmd_out: register map, handshake, overflow and
// asynchronous reset behaviour with hand-computed expectations.
module tb_soc_system_cmd_out;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  soc_system_cmd_out_if #(.DATA_WIDTH(8)) bus ();

  soc_system_cmd_out #(
    .DATA_WIDTH (8),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one bus write for a single cycle, with out_ready held at rdy.
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data, input logic rdy);
    @(negedge clk);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.out_ready  = rdy;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.out_ready  = 1'b0;
  endtask

  // Read without chipselect: readdata is registered from address every cycle.
  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.address = addr;
    @(posedge clk);
    #1;
    data = bus.readdata;
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    checks         = 0;
    failures       = 0;
    reset_n        = 1'b0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    bus.out_ready  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_port", 32'(bus.out_port), 32'h00);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_readdata", bus.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    bus_read(2'd0, rd);
    check("rd_data_after_rst", rd, 32'h00);
    bus_read(2'd1, rd);
    check("rd_status_after_rst", rd, 32'h0);

    // Plain DATA write, then handshake.
    bus_write(2'd0, 32'h0000_00A5, 1'b0);
    check("wr_a5_out_port", 32'(bus.out_port), 32'hA5);
    check("wr_a5_valid", 32'(bus.out_valid), 32'h1);
    bus_read(2'd1, rd);
    check("status_pending", rd, 32'h1);
    pulse_ready();
    check("valid_drop_after_ready", 32'(bus.out_valid), 32'h0);
    check("out_port_held_after_xfer", 32'(bus.out_port), 32'hA5);

    // SET / CLEAR aliases; upper writedata bits must be ignored.
    bus_write(2'd0, 32'hFFFF_FFA0, 1'b0);
    pulse_ready();
    bus_write(2'd2, 32'h0000_000F, 1'b0);
    check("set_out_port", 32'(bus.out_port), 32'hAF);
    check("set_valid", 32'(bus.out_valid), 32'h1);
    pulse_ready();
    bus_write(2'd3, 32'h0000_0081, 1'b0);
    check("clear_out_port", 32'(bus.out_port), 32'h2E);
    pulse_ready();
    bus_read(2'd0, rd);
    check("rd_data_2e", rd, 32'h2E);
    bus_read(2'd2, rd);
    check("rd_set_zero", rd, 32'h0);
    bus_read(2'd3, rd);
    check("rd_clear_zero", rd, 32'h0);

    // Overflow: write dropped while pending.
    bus_write(2'd0, 32'h11, 1'b0);
    bus_write(2'd0, 32'h22, 1'b0);
    check("ovf_out_port_kept", 32'(bus.out_port), 32'h11);
    bus_read(2'd1, rd);
    check("status_ovf", rd, 32'h3);
    bus_write(2'd1, 32'h2, 1'b0);
    bus_read(2'd1, rd);
    check("status_ovf_cleared", rd, 32'h1);

    // Back-to-back: command write in the completing cycle.
    bus_write(2'd0, 32'h33, 1'b1);
    check("b2b_valid", 32'(bus.out_valid), 32'h1);
    check("b2b_out_port", 32'(bus.out_port), 32'h33);
    bus_read(2'd1, rd);
    check("b2b_no_ovf", rd, 32'h1);
    pulse_ready();
    check("b2b_done", 32'(bus.out_valid), 32'h0);

    // Asynchronous reset in the middle of a pending command.
    bus_write(2'd0, 32'h55, 1'b0);
    check("pre_rst_out_port", 32'(bus.out_port), 32'h55);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out_port", 32'(bus.out_port), 32'h00);
    check("async_rst_valid", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    pulse_ready();
    check("idle_ready_ignored", 32'(bus.out_valid), 32'h0);
    check("idle_ready_port", 32'(bus.out_port), 32'h00);
    bus_read(2'd1, rd);
    check("status_after_async_rst", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/soc_system_cmd_out.md
# soc_system_cmd_out

Avalon-MM slave output port for the HPS-to-fabric direction: the HPS writes a command word over the lightweight bridge, and the block presents it on `out_port` with a valid/ready handshake to fabric logic. Set and clear aliases allow single-bit updates without read-modify-write. A sticky overflow flag records writes dropped while a command is still pending. It sits beside the fabric status input PIO in `soc_system`, and software polls both through the same bridge.

## Interface
- `DATA_WIDTH`, default 8: width of `out_port` and of the stored data register (1..32).
- `RESET_VALUE`, default 0: value of the data register and `out_port` after reset.
- `clk`  input  1  system clock; every register is clocked on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `address`  input  2  word address on the Avalon-MM slave.
- `chipselect`  input  1  slave select.
- `write_n`  input  1  active-low write strobe.
- `writedata`  input  32  write data.
- `readdata`  output  32  registered read data.
- `out_port`  output  DATA_WIDTH  current command value, registered.
- `out_valid`  output  1  high while a command is pending toward the fabric.
- `out_ready`  input  1  fabric accepts the pending command.

## Operation
- Register map (word addresses):
  - 0 DATA: R/W. Bits [DATA_WIDTH-1:0].
  - 1 STATUS: RO bit0 = `pending` (equals `out_valid`); bit1 = `overflow`, sticky, cleared by writing 1 (W1C).
  - 2 SET: WO. `data |= writedata`.
  - 3 CLEAR: WO. `data &= ~writedata`.
- Upper bits of `writedata` beyond DATA_WIDTH are ignored. Reads of unused bits return 0. Reads of SET and CLEAR return 0.
- A write cycle is a cycle with `chipselect==1 && write_n==0`. A command write is a write cycle to address 0, 2 or 3.
- FSM states:
  - IDLE (`out_valid=0`): a command write updates `data`. The next state is PEND.
  - PEND (`out_valid=1`): if `out_ready==1`, the transfer completes. The next state is IDLE, unless a command write occurs in the same cycle; in that case `data` updates and the state stays PEND (back-to-back transfer).
  - PEND, command write without `out_ready`: the write is dropped, `data` is unchanged and `overflow` is set.
- A STATUS write with bit1=1 clears `overflow`. If an overflow event happens in the same cycle, set wins.
- `out_port` is driven directly from `data`. `out_port` is stable for the whole PEND period.
- Reset values:
  - `data` = `out_port` = RESET_VALUE.
  - `out_valid` = 0, `overflow` = 0, `readdata` = 0, state IDLE.

## Timing
- `readdata` is registered every cycle from `address`, independent of `chipselect`. Read latency is 1 cycle, with zero wait states.
- A write at edge N updates `data`, `out_port` and `out_valid` after edge N, so they are visible in cycle N+1.
- A handshake completes at an edge where `out_valid && out_ready`. `out_valid` falls after that edge unless a simultaneous command write re-arms it.
- `out_ready` while `out_valid==0` is ignored.
- Reset asserted mid-PEND: the block returns immediately (asynchronously) to reset values. No transfer is reported.
- A read of STATUS in the same cycle as a state change returns the pre-edge value.

## Structure
- Shared package `soc_system_pio_pkg`:
  - address constants `ADDR_DATA`=0, `ADDR_STATUS`=1, `ADDR_SET`=2, `ADDR_CLEAR`=3
  - STATUS bit indices `STAT_PENDING`=0, `STAT_OVERFLOW`=1
  - 1-bit FSM state enum (IDLE, PEND)
- There is no sub-module. Write decode, next-data mux, FSM and read mux stay in one file.

## Test plan
- Reset, then read DATA and STATUS → readdata 0x00 and 0x0. `out_port` = 0x00, `out_valid` = 0.
- Write DATA=0xA5 with `out_ready` held 0 → `out_port` = 0xA5 and `out_valid` = 1 from the next cycle. STATUS reads 0x1. Pulse `out_ready` for one cycle → `out_valid` = 0 the cycle after.
- Write SET=0x0F after DATA=0xA0 has completed, then complete the handshake; write CLEAR=0x81 → `out_port` goes 0xAF, then 0x2E. DATA reads back 0x2E.
- While PEND with DATA=0x11, write DATA=0x22 with `out_ready` held 0 → `out_port` stays 0x11 and STATUS reads 0x3. Write STATUS=0x2 → STATUS reads 0x1.
- While PEND, write DATA=0x33 in the same cycle as `out_ready` is 1 → `out_valid` stays 1, `out_port` = 0x33, `overflow` stays 0.
- Assert `reset_n` low mid-PEND with `out_port`=0x55 → `out_port` = RESET_VALUE and `out_valid` = 0 without waiting for a clock edge. After release, `out_ready` pulses are ignored.
